// File: rtl/rocketcpu_audio_regbank.sv
// Wishbone-slave bank of 32-bit audio parameter registers with byte-lane writes.
// Define AUDIO_REGBANK_SHADOW_EN to add a shadow bank committed atomically on i_sample_tick.
module rocketcpu_audio_regbank #(
  parameter int          NUM_REGS  = 18,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rst,
  input  logic [31:0]             i_wb_adr,
  input  logic [31:0]             i_wb_dat,
  input  logic [3:0]              i_wb_sel,
  input  logic                    i_wb_we,
  input  logic                    i_wb_cyc,
  output logic [31:0]             o_wb_rdt,
  output logic                    o_wb_ack,
  input  logic                    i_sample_tick,
  output logic [32*NUM_REGS-1:0]  o_params,
  output logic                    o_commit_done
);

  logic                         accept;
  logic [29:0]                  word_off;
  logic                         reg_hit;
  logic                         ctrl_hit;
  logic                         wr_en;
  logic [31:0]                  ctrl_rd;
  logic [31:0]                  rd_data;
  logic                         commit;
  logic [NUM_REGS-1:0][31:0]    live;
  logic [NUM_REGS-1:0][31:0]    tgt;

  assign accept   = i_wb_cyc & ~o_wb_ack;
  // Offset from the base in words; wraps for addresses below the base, so they fall out of range.
  assign word_off = i_wb_adr[31:2] - BASE_ADDR[31:2];
  assign reg_hit  = word_off < 30'(NUM_REGS);
  assign ctrl_hit = word_off == 30'(NUM_REGS);
  assign wr_en    = accept & i_wb_we & reg_hit;
  assign o_params = live;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[b*8 +: 8] = dat[b*8 +: 8];
    return r;
  endfunction

`ifdef AUDIO_REGBANK_SHADOW_EN
  typedef enum logic {IDLE, ARMED} state_t;

  state_t                    state_q, state_d;
  logic [NUM_REGS-1:0][31:0] shadow;
  logic                      ctrl_wr;

  assign tgt     = shadow;
  assign ctrl_wr = accept & i_wb_we & ctrl_hit & i_wb_sel[0];
  assign ctrl_rd = {30'b0, state_q == ARMED, 1'b1};

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q       <= IDLE;
      o_commit_done <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_commit_done <= commit;
    end
  end

  // Abort outranks both arming and a pending tick.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_wr && !i_wb_dat[1] && i_wb_dat[0]) state_d = ARMED;
      end
      ARMED: begin
        if (ctrl_wr && i_wb_dat[1]) state_d = IDLE;
        else if (i_sample_tick) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit reads the pre-write shadow, so a same-edge write waits for the next commit.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      live   <= '0;
      shadow <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit) live[i] <= shadow[i];
        if (wr_en && word_off == 30'(i)) shadow[i] <= merge(shadow[i], i_wb_dat, i_wb_sel);
      end
    end
  end
`else
  logic unused_tick;

  assign unused_tick   = i_sample_tick;
  assign tgt           = live;
  assign ctrl_rd       = 32'h0;
  assign commit        = 1'b0;
  assign o_commit_done = 1'b0;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      live <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_en && word_off == 30'(i)) live[i] <= merge(live[i], i_wb_dat, i_wb_sel);
    end
  end
`endif

  logic [1:0] unused_adr;
  assign unused_adr = i_wb_adr[1:0];

  always_comb begin
    rd_data = 32'h0;
    if (reg_hit) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (word_off == 30'(i)) rd_data = tgt[i];
    end else if (ctrl_hit) begin
      rd_data = ctrl_rd;
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'h0;
    end else begin
      o_wb_ack <= i_wb_cyc & ~o_wb_ack;
      if (accept && !i_wb_we) o_wb_rdt <= rd_data;
    end
  end

endmodule

// File: tb/tb_rocketcpu_audio_regbank.sv
// Randomized bench for rocketcpu_audio_regbank against an array-based model of the register map.
module tb_rocketcpu_audio_regbank;
  localparam int          NR   = 18;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef AUDIO_REGBANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       adr = '0, dat = '0;
  logic [3:0]        sel = '0;
  logic              we = 1'b0, cyc = 1'b0, tick = 1'b0;
  logic [31:0]       rdt;
  logic              ack, commit_done;
  logic [32*NR-1:0]  params;

  rocketcpu_audio_regbank #(.NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack),
    .i_sample_tick(tick), .o_params(params), .o_commit_done(commit_done)
  );

  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] m_tgt  [NR];
  logic [31:0] m_live [NR];
  bit          m_armed;
  logic [31:0] rv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_params(input string tag);
    for (int i = 0; i < NR; i++) chk(tag, params[32*i +: 32], m_live[i]);
  endtask

  function automatic int decode(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) - (BASE >> 2);
    if (a < BASE || w > NR) return -1;
    return int'(w);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_tgt[i] = 0; m_live[i] = 0; end
    m_armed = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc = 0; tick = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One Wibshone access, optionally with a sample tick in the accepting cycle.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit w, input bit t, output logic [31:0] r);
    int          idx;
    logic [31:0] exp_rd, mask;
    bit          was_armed, do_commit, ctrl_wr;
    idx = decode(a);
    adr = a; dat = d; sel = s; we = w; cyc = 1; tick = t;
    chk("ack_before_edge", {31'b0, ack}, 32'h0);
    exp_rd = 0;
    if (idx >= 0 && idx < NR) exp_rd = m_tgt[idx];
    else if (idx == NR && SHADOW) exp_rd = {30'b0, m_armed, 1'b1};
    was_armed = m_armed;
    do_commit = 0;
    ctrl_wr = SHADOW && w && idx == NR && s[0];
    if (ctrl_wr) begin
      if (d[1]) m_armed = 0;
      else if (d[0]) m_armed = 1;
    end
    if (SHADOW && was_armed && t && !(ctrl_wr && d[1])) begin
      do_commit = 1;
      for (int i = 0; i < NR; i++) m_live[i] = m_tgt[i];
      m_armed = 0;
    end
    if (w && idx >= 0 && idx < NR) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      m_tgt[idx] = (m_tgt[idx] & ~mask) | (d & mask);
      if (!SHADOW) m_live[idx] = m_tgt[idx];
    end
    @(posedge clk); #1;
    cyc = 0; we = 0; tick = 0;
    chk("ack", {31'b0, ack}, 32'h1);
    r = rdt;
    if (!w) chk("rdt", rdt, exp_rd);
    chk("commit_done", {31'b0, commit_done}, {31'b0, do_commit});
    check_params("params");
    @(posedge clk); #1;
    chk("ack_drop", {31'b0, ack}, 32'h0);
    chk("commit_pulse_end", {31'b0, commit_done}, 32'h0);
  endtask

  task automatic tick_only();
    bit do_commit;
    do_commit = SHADOW && m_armed;
    if (do_commit) begin
      for (int i = 0; i < NR; i++) m_live[i] = m_tgt[i];
      m_armed = 0;
    end
    tick = 1;
    @(posedge clk); #1 tick = 0;
    chk("tick_commit_done", {31'b0, commit_done}, {31'b0, do_commit});
    check_params("tick_params");
    @(posedge clk); #1;
    chk("tick_pulse_end", {31'b0, commit_done}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    int          k;
    do_reset();
    check_params("reset_params");
    chk("reset_ack", {31'b0, ack}, 32'h0);
    chk("reset_rdt", rdt, 32'h0);
    chk("reset_commit", {31'b0, commit_done}, 32'h0);
    xfer(BASE + 32'h14, 0, 4'hF, 0, 0, rv);
    chk("reset_reg5", rv, 32'h0);

    xfer(BASE + 32'hC, 32'hAABBCCDD, 4'hF, 1, 0, rv);
    xfer(BASE + 32'hC, 32'h11223344, 4'b0101, 1, 0, rv);
    xfer(BASE + 32'hC, 0, 4'hF, 0, 0, rv);
    chk("byte_lanes", rv, 32'hAA22CC44);
    xfer(BASE + 32'hC, 32'hFFFFFFFF, 4'h0, 1, 0, rv);
    xfer(BASE + 32'hC, 0, 4'hF, 0, 0, rv);
    chk("sel_zero", rv, 32'hAA22CC44);

    xfer(BASE + 32'h4C, 32'hDEADBEEF, 4'hF, 1, 0, rv);
    xfer(BASE + 32'h4C, 0, 4'hF, 0, 0, rv);
    chk("unmapped_read", rv, 32'h0);
    xfer(BASE ^ 32'h8000_0000, 32'hCAFEF00D, 4'hF, 1, 0, rv);
    xfer(BASE - 4, 32'hCAFEF00D, 4'hF, 1, 0, rv);
    xfer(BASE + 32'h44, 32'h1234, 4'hF, 1, 0, rv);
    xfer(BASE + 32'h44, 0, 4'hF, 0, 0, rv);
    chk("last_reg", rv, 32'h1234);

`ifdef AUDIO_REGBANK_SHADOW_EN
    do_reset();
    xfer(BASE, 7, 4'hF, 1, 0, rv);
    xfer(BASE + 4, 9, 4'hF, 1, 0, rv);
    chk("shadow_hold0", params[31:0], 32'h0);
    xfer(BASE + 32'h48, 1, 4'h1, 1, 0, rv);
    repeat (3) @(posedge clk);
    #1 check_params("armed_no_tick");
    xfer(BASE + 32'h48, 0, 4'hF, 0, 0, rv);
    chk("ctrl_armed", rv, 32'h3);
    tick_only();
    chk("commit_r0", params[31:0], 32'd7);
    chk("commit_r1", params[63:32], 32'd9);
    xfer(BASE + 32'h48, 0, 4'hF, 0, 0, rv);
    chk("ctrl_idle", rv, 32'h1);
    xfer(BASE, 32'h77, 4'hF, 1, 0, rv);
    xfer(BASE + 32'h48, 1, 4'h1, 1, 1, rv);
    chk("arm_tick_hold", params[31:0], 32'd7);
    tick_only();
    chk("arm_tick_next", params[31:0], 32'h77);
    xfer(BASE + 32'h48, 1, 4'h1, 1, 0, rv);
    xfer(BASE, 32'h88, 4'hF, 1, 1, rv);
    chk("write_tick_old", params[31:0], 32'h77);
    xfer(BASE + 32'h48, 1, 4'h1, 1, 0, rv);
    xfer(BASE + 32'h48, 2, 4'h1, 1, 0, rv);
    tick_only();
    chk("abort_hold", params[31:0], 32'h77);
    xfer(BASE + 32'h48, 3, 4'h1, 1, 0, rv);
    xfer(BASE + 32'h48, 0, 4'hF, 0, 0, rv);
    chk("abort_wins", rv, 32'h1);
    xfer(BASE + 32'h48, 1, 4'h1, 1, 0, rv);
    do_reset();
    tick_only();
    check_params("reset_armed");
`else
    xfer(BASE + 8, 32'h55, 4'hF, 1, 0, rv);
    chk("live_slice2", params[95:64], 32'h55);
    xfer(BASE + 32'h48, 32'h1, 4'hF, 1, 0, rv);
    xfer(BASE + 32'h48, 0, 4'hF, 0, 0, rv);
    chk("ctrl_zero", rv, 32'h0);
    tick_only();
    tick_only();
`endif

    for (int n = 0; n < 300; n++) begin
      k = int'($urandom_range(0, 23));
      if (k < 21) a = BASE + 32'(4 * k);
      else if (k == 21) a = BASE ^ (32'h1 << $urandom_range(2, 31));
      else a = $urandom;
      a[1:0] = 2'($urandom_range(0, 3));
      d = $urandom;
      if (decode(a) == NR && $urandom_range(0, 1) == 1) d[1] = 1'b0;
      xfer(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, 0, rv);
      if ($urandom_range(0, 4) == 0) tick_only();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
